// File: rtl/puf_resp_collector.sv
// puf_resp_collector: requests challenges, majority-votes REPEAT PUF evaluations per bit
// and shifts the voted bits into a RESP_BITS-wide key with instability and timeout reporting.
module puf_resp_collector #(
    parameter int CHAL_W    = 128,
    parameter int RESP_BITS = 32,
    parameter int REPEAT    = 3,
    parameter int TIMEOUT   = 255
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    output logic                 error,
    output logic [RESP_BITS-1:0] key,
    output logic [6:0]           unstable_cnt,
    output logic                 rng_request,
    input  logic                 rng_ready,
    input  logic [CHAL_W-1:0]    rng_challenge,
    output logic [CHAL_W-1:0]    puf_challenge,
    output logic                 puf_start,
    input  logic                 puf_valid,
    input  logic                 puf_bit
);
    typedef enum logic [2:0] {IDLE, REQ, WAIT_RNG, EVAL, WAIT_PUF, DECIDE, DONE} state_t;

    state_t                state_q, state_d;
    logic [RESP_BITS-1:0]  key_q, key_d;
    logic [6:0]            unst_q, unst_d;
    logic                  err_q, err_d;
    logic [CHAL_W-1:0]     chal_q, chal_d;
    logic [6:0]            bit_idx_q, bit_idx_d;
    logic [3:0]            eval_q, eval_d;
    logic [3:0]            ones_q, ones_d;
    logic [7:0]            tmo_q, tmo_d;
    logic                  tmo_hit, vote, split;

    always_comb begin
        tmo_hit = tmo_q == 8'(TIMEOUT);
        vote    = {1'b0, ones_q} << 1 > 5'(REPEAT);
        split   = ones_q != 4'd0 && ones_q != 4'(REPEAT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            key_q     <= '0;
            unst_q    <= '0;
            err_q     <= 1'b0;
            chal_q    <= '0;
            bit_idx_q <= '0;
            eval_q    <= '0;
            ones_q    <= '0;
            tmo_q     <= '0;
        end else begin
            state_q   <= state_d;
            key_q     <= key_d;
            unst_q    <= unst_d;
            err_q     <= err_d;
            chal_q    <= chal_d;
            bit_idx_q <= bit_idx_d;
            eval_q    <= eval_d;
            ones_q    <= ones_d;
            tmo_q     <= tmo_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     state_d = start ? REQ : IDLE;
            REQ:      state_d = WAIT_RNG;
            WAIT_RNG: state_d = rng_ready ? EVAL : (tmo_hit ? DONE : WAIT_RNG);
            EVAL:     state_d = WAIT_PUF;
            WAIT_PUF: state_d = puf_valid ? (eval_q + 4'd1 == 4'(REPEAT) ? DECIDE : EVAL)
                                          : (tmo_hit ? DONE : WAIT_PUF);
            DECIDE:   state_d = bit_idx_q + 7'd1 == 7'(RESP_BITS) ? DONE : REQ;
            default:  state_d = IDLE;
        endcase
    end

    // Datapath; the wait counter only runs inside the two wait states, so it restarts on entry.
    always_comb begin
        key_d     = key_q;
        unst_d    = unst_q;
        err_d     = err_q;
        chal_d    = chal_q;
        bit_idx_d = bit_idx_q;
        eval_d    = eval_q;
        ones_d    = ones_q;
        tmo_d     = (state_q == WAIT_RNG || state_q == WAIT_PUF) ? tmo_q + 8'd1 : 8'd0;
        case (state_q)
            IDLE: if (start) begin
                key_d     = '0;
                unst_d    = '0;
                err_d     = 1'b0;
                bit_idx_d = '0;
                ones_d    = '0;
            end
            WAIT_RNG: if (rng_ready) begin
                chal_d = rng_challenge;
                eval_d = '0;
                ones_d = '0;
            end else if (tmo_hit) err_d = 1'b1;
            WAIT_PUF: if (puf_valid) begin
                ones_d = ones_q + {3'b0, puf_bit};
                eval_d = eval_q + 4'd1;
            end else if (tmo_hit) err_d = 1'b1;
            DECIDE: begin
                key_d     = {key_q[RESP_BITS-2:0], vote};
                unst_d    = (split && unst_q != 7'd127) ? unst_q + 7'd1 : unst_q;
                bit_idx_d = bit_idx_q + 7'd1;
            end
            default: ;
        endcase
    end

    always_comb begin
        busy          = state_q != IDLE;
        done          = state_q == DONE;
        rng_request   = state_q == REQ;
        puf_start     = state_q == EVAL;
        error         = err_q;
        key           = key_q;
        unstable_cnt  = unst_q;
        puf_challenge = chal_q;
    end
endmodule

// File: tb/tb_puf_resp_collector.sv
// tb_puf_resp_collector: directed scenarios against a 4-bit/3-vote collector and a 4-bit/2-vote
// collector, with generator and PUF behavioural models answering after two cycles.
module tb_puf_resp_collector;
    localparam int CW  = 128;
    localparam int RB  = 4;
    localparam int TMO = 255;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, start, busy, done, error;
    logic [RB-1:0] key;
    logic [6:0]    unstable_cnt;
    logic          rng_request, rng_ready, puf_start, puf_valid, puf_bit;
    logic [CW-1:0] rng_challenge, puf_challenge;

    logic          start2, busy2, done2, error2;
    logic [RB-1:0] key2;
    logic [6:0]    unst2;
    logic          rng_request2, rng_ready2, puf_start2, puf_valid2, puf_bit2;
    logic [CW-1:0] rng_challenge2, puf_challenge2;

    puf_resp_collector #(.CHAL_W(CW), .RESP_BITS(RB), .REPEAT(3), .TIMEOUT(TMO)) u_dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .error(error),
        .key(key), .unstable_cnt(unstable_cnt), .rng_request(rng_request),
        .rng_ready(rng_ready), .rng_challenge(rng_challenge), .puf_challenge(puf_challenge),
        .puf_start(puf_start), .puf_valid(puf_valid), .puf_bit(puf_bit));

    puf_resp_collector #(.CHAL_W(CW), .RESP_BITS(RB), .REPEAT(2), .TIMEOUT(TMO)) u_dut2 (
        .clk(clk), .rst(rst), .start(start2), .busy(busy2), .done(done2), .error(error2),
        .key(key2), .unstable_cnt(unst2), .rng_request(rng_request2),
        .rng_ready(rng_ready2), .rng_challenge(rng_challenge2), .puf_challenge(puf_challenge2),
        .puf_start(puf_start2), .puf_valid(puf_valid2), .puf_bit(puf_bit2));

    int compared = 0;
    int mismatched = 0;

    bit            gen_en;
    int            hold_bit;
    bit            ovr_en [32];
    bit            ovr_v  [32];
    int            inj_req = 0;
    logic [CW-1:0] inj_chal;
    bit            seq [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    int            n_req = 0, n_pst = 0, n_done = 0;

    // Generator + PUF model for the 3-vote instance; PUF answers with challenge bit 0 unless overridden.
    initial begin
        int gcnt, pcnt, gen_idx, pidx, inj_ack;
        gcnt = 0; pcnt = 0; gen_idx = 0; pidx = 0; inj_ack = 0;
        rng_ready = 0; rng_challenge = '0; puf_valid = 0; puf_bit = 0;
        forever begin
            @(negedge clk);
            rng_ready = 0;
            puf_valid = 0;
            if (rst) begin
                gcnt = 0;
                pcnt = 0;
            end else begin
                if (!busy) begin
                    gen_idx = 0;
                    pidx = 0;
                end
                if (gcnt > 0) begin
                    gcnt--;
                    if (gcnt == 0) begin
                        rng_ready = 1;
                        rng_challenge = {32'(gen_idx - 1), 95'h0, seq[(gen_idx - 1) % 4]};
                    end
                end
                if (inj_req != inj_ack) begin
                    inj_ack = inj_req;
                    rng_ready = 1;
                    rng_challenge = inj_chal;
                end
                if (pcnt > 0) begin
                    pcnt--;
                    if (pcnt == 0) begin
                        puf_valid = 1;
                        puf_bit = ovr_en[pidx] ? ovr_v[pidx] : puf_challenge[0];
                        pidx++;
                    end
                end
                if (rng_request && gen_en) begin
                    gcnt = 2;
                    gen_idx++;
                end
                if (puf_start && gen_idx - 1 != hold_bit) pcnt = 2;
            end
        end
    end

    // Model for the 2-vote instance: every bit is evaluated as 1 then 0.
    initial begin
        int g2, p2;
        bit par;
        g2 = 0; p2 = 0; par = 0;
        rng_ready2 = 0; rng_challenge2 = '0; puf_valid2 = 0; puf_bit2 = 0;
        forever begin
            @(negedge clk);
            rng_ready2 = 0;
            puf_valid2 = 0;
            if (rst) begin
                g2 = 0; p2 = 0; par = 0;
            end else begin
                if (g2 > 0) begin
                    g2--;
                    if (g2 == 0) begin
                        rng_ready2 = 1;
                        rng_challenge2 = {CW{1'b1}};
                    end
                end
                if (p2 > 0) begin
                    p2--;
                    if (p2 == 0) begin
                        puf_valid2 = 1;
                        puf_bit2 = ~par;
                        par = ~par;
                    end
                end
                if (rng_request2) g2 = 2;
                if (puf_start2) p2 = 2;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (rng_request === 1'b1) n_req++;
            if (puf_start === 1'b1) n_pst++;
            if (done === 1'b1) n_done++;
        end
    end

    task automatic cfg_clear();
        gen_en = 1;
        hold_bit = -1;
        for (int i = 0; i < 32; i++) begin
            ovr_en[i] = 0;
            ovr_v[i] = 0;
        end
    endtask

    task automatic pulse_start();
        start = 1;
        @(negedge clk);
        start = 0;
    endtask

    task automatic wait_done(input int budget, output int n);
        n = 0;
        while (done !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        compared++;
        if (done !== 1'b1) begin
            mismatched++;
            $display("FAIL done_wait: done=%b after %0d cycles, required 1", done, n);
        end
    endtask

    task automatic wait_pst(input int count);
        int r = 0;
        for (int n = 0; n < 400; n++) begin
            if (puf_start === 1'b1) r++;
            if (r == count) break;
            @(negedge clk);
        end
        compared++;
        if (r != count) begin
            mismatched++;
            $display("FAIL pst_wait: saw %0d puf_start pulses, required %0d", r, count);
        end
    endtask

    task automatic test_reset();
        rst = 1; start = 0; start2 = 0;
        repeat (3) @(negedge clk);
        rst = 0;
        compared++;
        if ({busy, done, error, key, unstable_cnt, rng_request, puf_start} !== '0) begin
            mismatched++;
            $display("FAIL reset_outs: got %b required 0",
                     {busy, done, error, key, unstable_cnt, rng_request, puf_start});
        end
        compared++;
        if (puf_challenge !== '0) begin
            mismatched++;
            $display("FAIL reset_chal: got %h required 0", puf_challenge);
        end
    endtask

    task automatic test_basic();
        int n, r0, p0, d0;
        cfg_clear();
        r0 = n_req; p0 = n_pst; d0 = n_done;
        pulse_start();
        wait_done(200, n);
        compared++;
        if (n != 52) begin
            mismatched++;
            $display("FAIL basic_latency: got %0d cycles required 52", n);
        end
        compared++;
        if ({key, unstable_cnt, error, busy} !== {4'b1011, 7'd0, 1'b0, 1'b1}) begin
            mismatched++;
            $display("FAIL basic_result: key=%b unst=%0d err=%b busy=%b required 1011/0/0/1",
                     key, unstable_cnt, error, busy);
        end
        @(negedge clk);
        compared++;
        if ({busy, done} !== 2'b00) begin
            mismatched++;
            $display("FAIL basic_idle: busy/done=%b required 00", {busy, done});
        end
        compared++;
        if (n_req - r0 != 4 || n_pst - p0 != 12 || n_done - d0 != 1) begin
            mismatched++;
            $display("FAIL basic_pulses: req=%0d pst=%0d done=%0d required 4/12/1",
                     n_req - r0, n_pst - p0, n_done - d0);
        end
        compared++;
        if (puf_challenge !== {32'd3, 95'h0, 1'b1}) begin
            mismatched++;
            $display("FAIL basic_chal: got %h required %h", puf_challenge, {32'd3, 95'h0, 1'b1});
        end
    endtask

    task automatic test_unstable();
        int n, r;
        cfg_clear();
        for (int i = 6; i < 12; i++) ovr_en[i] = 1;
        ovr_v[6] = 1; ovr_v[7] = 0; ovr_v[8] = 1;
        ovr_v[9] = 0; ovr_v[10] = 1; ovr_v[11] = 0;
        pulse_start();
        r = 0;
        for (int k = 0; k < 200; k++) begin
            if (rng_request === 1'b1) r++;
            if (r == 4) break;
            @(negedge clk);
        end
        compared++;
        if (r != 4 || key !== 4'b0101 || unstable_cnt !== 7'd1) begin
            mismatched++;
            $display("FAIL unst_mid: reqs=%0d key=%b unst=%0d required 4/0101/1", r, key, unstable_cnt);
        end
        wait_done(200, n);
        compared++;
        if ({key, unstable_cnt, error} !== {4'b1010, 7'd2, 1'b0}) begin
            mismatched++;
            $display("FAIL unst_final: key=%b unst=%0d err=%b required 1010/2/0", key, unstable_cnt, error);
        end
        @(negedge clk);
    endtask

    task automatic test_tie();
        int n = 0;
        start2 = 1;
        @(negedge clk);
        start2 = 0;
        while (done2 !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        compared++;
        if (done2 !== 1'b1 || n != 40) begin
            mismatched++;
            $display("FAIL tie_latency: done2=%b after %0d cycles required 1 after 40", done2, n);
        end
        compared++;
        if ({key2, unst2, error2} !== {4'b0000, 7'd4, 1'b0}) begin
            mismatched++;
            $display("FAIL tie_result: key=%b unst=%0d err=%b required 0000/4/0", key2, unst2, error2);
        end
        @(negedge clk);
    endtask

    task automatic test_timeout_rng();
        int n;
        cfg_clear();
        gen_en = 0;
        pulse_start();
        wait_done(400, n);
        compared++;
        if (n != TMO + 2) begin
            mismatched++;
            $display("FAIL tmo_rng_latency: got %0d cycles required %0d", n, TMO + 2);
        end
        compared++;
        if ({error, key, busy} !== {1'b1, 4'b0000, 1'b1}) begin
            mismatched++;
            $display("FAIL tmo_rng_result: err=%b key=%b busy=%b required 1/0000/1", error, key, busy);
        end
        @(negedge clk);
        compared++;
        if ({busy, error} !== 2'b01) begin
            mismatched++;
            $display("FAIL tmo_rng_after: busy/err=%b required 01", {busy, error});
        end
    endtask

    task automatic test_timeout_puf();
        int n;
        cfg_clear();
        hold_bit = 1;
        pulse_start();
        wait_pst(4);
        wait_done(400, n);
        compared++;
        if (n != TMO + 2) begin
            mismatched++;
            $display("FAIL tmo_puf_latency: got %0d cycles required %0d", n, TMO + 2);
        end
        compared++;
        if ({error, key, unstable_cnt} !== {1'b1, 4'b0001, 7'd0}) begin
            mismatched++;
            $display("FAIL tmo_puf_result: err=%b key=%b unst=%0d required 1/0001/0", error, key, unstable_cnt);
        end
        @(negedge clk);
    endtask

    task automatic test_busy_ignore();
        int n, r0, p0, d0;
        cfg_clear();
        r0 = n_req; p0 = n_pst; d0 = n_done;
        pulse_start();
        wait_pst(1);
        inj_chal = '0;
        inj_req++;
        pulse_start();
        wait_done(300, n);
        compared++;
        if ({key, unstable_cnt, error} !== {4'b1011, 7'd0, 1'b0}) begin
            mismatched++;
            $display("FAIL busy_result: key=%b unst=%0d err=%b required 1011/0/0", key, unstable_cnt, error);
        end
        pulse_start();
        compared++;
        if (busy !== 1'b0) begin
            mismatched++;
            $display("FAIL busy_done_start: busy=%b required 0", busy);
        end
        @(negedge clk);
        compared++;
        if (n_req - r0 != 4 || n_pst - p0 != 12 || n_done - d0 != 1) begin
            mismatched++;
            $display("FAIL busy_pulses: req=%0d pst=%0d done=%0d required 4/12/1",
                     n_req - r0, n_pst - p0, n_done - d0);
        end
    endtask

    task automatic test_reset_mid();
        int n, d0;
        cfg_clear();
        pulse_start();
        wait_pst(7);
        @(negedge clk);
        compared++;
        if (key !== 4'b0010) begin
            mismatched++;
            $display("FAIL rstmid_before: key=%b required 0010", key);
        end
        d0 = n_done;
        rst = 1;
        @(negedge clk);
        rst = 0;
        compared++;
        if ({busy, done, error, key, unstable_cnt, rng_request, puf_start} !== '0 || puf_challenge !== '0) begin
            mismatched++;
            $display("FAIL rstmid_outs: got %b chal=%h required all 0",
                     {busy, done, error, key, unstable_cnt, rng_request, puf_start}, puf_challenge);
        end
        repeat (30) @(negedge clk);
        compared++;
        if (n_done != d0 || busy !== 1'b0) begin
            mismatched++;
            $display("FAIL rstmid_nodone: done pulses=%0d busy=%b required 0/0", n_done - d0, busy);
        end
        pulse_start();
        wait_done(200, n);
        compared++;
        if ({key, unstable_cnt, error} !== {4'b1011, 7'd0, 1'b0}) begin
            mismatched++;
            $display("FAIL rstmid_rerun: key=%b unst=%0d err=%b required 1011/0/0", key, unstable_cnt, error);
        end
        @(negedge clk);
    endtask

    initial begin
        cfg_clear();
        inj_chal = '0;
        test_reset();
        test_basic();
        test_unstable();
        test_tie();
        test_timeout_rng();
        test_timeout_puf();
        test_busy_ignore();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/puf_resp_collector.md
Name: puf_resp_collector

Overview:
- Downstream consumer of the PUF challenge generator: requests a 128-bit challenge, applies it to the PUF core, evaluates it REPEAT times, majority-votes one response bit.
- Repeats per bit to assemble a RESP_BITS-wide key and reports instability and timeout errors.
- Sits between the challenge generator and the key/ID consumer.

Parameters:
- CHAL_W, 128, challenge width; must match generator output.
- RESP_BITS, 32, response bits collected per run (2..64).
- REPEAT, 3, PUF evaluations per challenge (1..15).
- TIMEOUT, 255, max cycles waiting on rng_ready or puf_valid (8-bit counter).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a run; ignored while busy.
- busy  out  1  high from the cycle after accepted start until the done cycle, inclusive.
- done  out  1  one-cycle pulse at run end (success or error).
- error  out  1  set on timeout; held until next accepted start or rst.
- key  out  RESP_BITS  collected response; valid when done=1, held after.
- unstable_cnt  out  7  count of bits whose REPEAT evaluations were not unanimous.
- rng_request  out  1  request to generator; generator acts on rising edge.
- rng_ready  in  1  one-cycle pulse; rng_challenge valid that cycle.
- rng_challenge  in  CHAL_W  challenge from generator.
- puf_challenge  out  CHAL_W  latched challenge driven to PUF core.
- puf_start  out  1  one-cycle pulse launching one PUF evaluation.
- puf_valid  in  1  one-cycle pulse; puf_bit valid that cycle.
- puf_bit  in  1  single evaluation result.

Behaviour:
- Reset, synchronous: all outputs 0, key=0, unstable_cnt=0, puf_challenge=0, FSM=IDLE. A reset mid-run aborts with no done pulse.
- IDLE: start=1 clears key, unstable_cnt, error, bit_idx and ones_cnt, then goes to REQ.
- REQ, 1 cycle: rng_request=1, then go to WAIT_RNG. rng_request is 1 only in REQ, so there is always at least one low cycle between requests.
- WAIT_RNG:
  - On rng_ready: latch puf_challenge <= rng_challenge, clear eval_cnt and ones_cnt, go to EVAL.
  - rng_ready arriving in any other state is ignored.
- EVAL, 1 cycle: puf_start=1, reset wait counter, go to WAIT_PUF.
- WAIT_PUF:
  - On puf_valid: ones_cnt += puf_bit, eval_cnt += 1.
  - If eval_cnt reaches REPEAT, go to DECIDE; else return to EVAL.
  - puf_valid in the same cycle as puf_start is not counted.
- DECIDE, 1 cycle:
  - bit = (2*ones_cnt > REPEAT); ties (even REPEAT) resolve to 0.
  - key <= {key[RESP_BITS-2:0], bit}, so the first bit collected ends at the MSB.
  - If 0 < ones_cnt < REPEAT, unstable_cnt += 1 (saturates at 127).
  - bit_idx += 1. If bit_idx == RESP_BITS, go to DONE; else go to REQ.
- Timeout: in WAIT_RNG or WAIT_PUF, a counter increments each cycle.
  - The counter resets on entering either state.
  - Reaching TIMEOUT sets error=1 and goes to DONE; key keeps the partially shifted value.
- DONE, 1 cycle: done=1, busy=1, then go to IDLE. start in DONE is ignored.
- Latency, nominal: with the generator's 2-cycle request-to-ready and PUF latency L, one bit takes 1+2+REPEAT*(1+L)+1 cycles.
- start while busy: ignored, no effect.

Test Plan:
- RESP_BITS=4, REPEAT=3, PUF model returns puf_bit = challenge[0], latency 2; generator seeded so bit0 sequence is 1,0,1,1 → done after 4 requests, key=4'b1011, unstable_cnt=0, error=0, exactly 4 rng_request pulses, 12 puf_start pulses.
- Same config; on bit 2 the PUF returns 1,0,1 → that key bit=1 and unstable_cnt=1; on another bit it returns 0,1,0 → that key bit=0 and unstable_cnt=2.
- REPEAT=2 and the PUF returns 1,0 → tie resolves to bit=0, unstable_cnt increments by 1.
- rng_ready never asserted → error=1 and done pulse exactly TIMEOUT+1 cycles after entering WAIT_RNG, key=0, busy falls the cycle after done. Same for puf_valid withheld on bit 1 → key holds bit 0 only.
- start pulsed again while busy, and rng_ready injected during WAIT_PUF → no effect: counts and key unchanged, one run completes.
- rst asserted for 1 cycle during WAIT_PUF → next cycle all outputs 0, FSM IDLE, no done pulse. A following start runs normally to key=4'b1011.
